// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register: picks ALU operands, forwards from EX/MEM/WB,
// detects load-use hazards and honours back-pressure and flush.
module id_ex_operand_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [REG_AW-1:0] id_rs1_addr,
  input  logic [REG_AW-1:0] id_rs2_addr,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [XLEN-1:0]   id_pc,
  input  logic              id_use_imm,
  input  logic              id_use_pc,
  input  logic [3:0]        id_alu_ctrl,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic [XLEN-1:0]   ex_alu_result,
  input  logic              fwd_mem_we,
  input  logic [REG_AW-1:0] fwd_mem_rd,
  input  logic [XLEN-1:0]   fwd_mem_data,
  input  logic              fwd_wb_we,
  input  logic [REG_AW-1:0] fwd_wb_rd,
  input  logic [XLEN-1:0]   fwd_wb_data,
  input  logic              ex_ready,
  input  logic              flush,
  output logic [XLEN-1:0]   d1,
  output logic [XLEN-1:0]   d2,
  output logic [3:0]        control,
  output logic              ex_valid,
  output logic [REG_AW-1:0] ex_rd_addr,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic [XLEN-1:0]   ex_store_data,
  output logic              load_use_stall
);

  localparam logic [REG_AW-1:0] ZERO_REG = {REG_AW{1'b0}};
  localparam logic [XLEN-1:0]   ZERO_DAT = {XLEN{1'b0}};

  logic              ex_fwd_ok_s;
  logic [XLEN-1:0]   rs1_fwd_s;
  logic [XLEN-1:0]   rs2_fwd_s;
  logic              stall_s;
  logic              ready_s;
  logic              capture_s;
  logic              update_s;
  logic [XLEN-1:0]   d1_next_s;
  logic [XLEN-1:0]   d2_next_s;
  logic [XLEN-1:0]   store_next_s;
  logic [3:0]        ctrl_next_s;
  logic [REG_AW-1:0] rd_next_s;
  logic              rw_next_s;
  logic              mr_next_s;

  // A load in EX has no data yet, so it is excluded from EX forwarding and handled by the stall.
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [REG_AW-1:0] src,
    input logic [XLEN-1:0]   rf_data,
    input logic              ex_ok,
    input logic [REG_AW-1:0] ex_rd,
    input logic [XLEN-1:0]   ex_data,
    input logic              mem_we,
    input logic [REG_AW-1:0] mem_rd,
    input logic [XLEN-1:0]   mem_data,
    input logic              wb_we,
    input logic [REG_AW-1:0] wb_rd,
    input logic [XLEN-1:0]   wb_data
  );
    logic [XLEN-1:0] res;
    if (src == ZERO_REG) begin
      res = ZERO_DAT;
    end else if (ex_ok && (ex_rd == src)) begin
      res = ex_data;
    end else if (mem_we && (mem_rd == src)) begin
      res = mem_data;
    end else if (wb_we && (wb_rd == src)) begin
      res = wb_data;
    end else begin
      res = rf_data;
    end
    return res;
  endfunction

  // Forwarding, hazard detection and next-state selection for the EX register.
  always_comb begin
    ex_fwd_ok_s = ex_valid & ex_reg_write & ~ex_mem_read;
    rs1_fwd_s = fwd_sel(id_rs1_addr, id_rs1_data, ex_fwd_ok_s, ex_rd_addr, ex_alu_result,
                        fwd_mem_we, fwd_mem_rd, fwd_mem_data, fwd_wb_we, fwd_wb_rd, fwd_wb_data);
    rs2_fwd_s = fwd_sel(id_rs2_addr, id_rs2_data, ex_fwd_ok_s, ex_rd_addr, ex_alu_result,
                        fwd_mem_we, fwd_mem_rd, fwd_mem_data, fwd_wb_we, fwd_wb_rd, fwd_wb_data);
    // rs2 is checked even for immediate forms so stores stall conservatively.
    stall_s = id_valid & ex_valid & ex_mem_read & (ex_rd_addr != ZERO_REG) &
              ((~id_use_pc & (id_rs1_addr == ex_rd_addr)) | (id_rs2_addr == ex_rd_addr));
    ready_s   = ex_ready & ~stall_s & ~flush;
    capture_s = id_valid & ready_s;
    update_s  = flush | ex_ready;
    if (capture_s) begin
      d1_next_s    = id_use_pc  ? id_pc  : rs1_fwd_s;
      d2_next_s    = id_use_imm ? id_imm : rs2_fwd_s;
      store_next_s = rs2_fwd_s;
      ctrl_next_s  = id_alu_ctrl;
      rd_next_s    = id_rd_addr;
      rw_next_s    = id_reg_write;
      mr_next_s    = id_mem_read;
    end else begin
      d1_next_s    = ZERO_DAT;
      d2_next_s    = ZERO_DAT;
      store_next_s = ZERO_DAT;
      ctrl_next_s  = 4'b0000;
      rd_next_s    = ZERO_REG;
      rw_next_s    = 1'b0;
      mr_next_s    = 1'b0;
    end
  end

  assign id_ready       = ready_s;
  assign load_use_stall = stall_s;

  // EX register: bubble on reset, load on flush or free downstream, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid      <= 1'b0;
      d1            <= ZERO_DAT;
      d2            <= ZERO_DAT;
      ex_store_data <= ZERO_DAT;
      control       <= 4'b0000;
      ex_rd_addr    <= ZERO_REG;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
    end else if (update_s) begin
      ex_valid      <= capture_s;
      d1            <= d1_next_s;
      d2            <= d2_next_s;
      ex_store_data <= store_next_s;
      control       <= ctrl_next_s;
      ex_rd_addr    <= rd_next_s;
      ex_reg_write  <= rw_next_s;
      ex_mem_read   <= mr_next_s;
    end
  end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scenario bench for id_ex_operand_stage; expected EX contents are queued when
// stimulus is driven and compared after the following rising edge.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_ready;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
  logic        id_use_imm, id_use_pc, id_reg_write, id_mem_read;
  logic [3:0]  id_alu_ctrl;
  logic [31:0] ex_alu_result;
  logic        fwd_mem_we, fwd_wb_we;
  logic [4:0]  fwd_mem_rd, fwd_wb_rd;
  logic [31:0] fwd_mem_data, fwd_wb_data;
  logic        ex_ready, flush;
  logic [31:0] d1, d2, ex_store_data;
  logic [3:0]  control;
  logic        ex_valid, ex_reg_write, ex_mem_read, load_use_stall;
  logic [4:0]  ex_rd_addr;

  int n_checks = 0;
  int n_fail   = 0;
  logic [107:0] sb[$];
  logic [107:0] exp_v;
  wire  [107:0] obs = {ex_valid, control, d1, d2, ex_store_data, ex_rd_addr, ex_reg_write, ex_mem_read};
  localparam logic [107:0] BUBBLE = 108'd0;

  id_ex_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_pc(id_pc), .id_use_imm(id_use_imm),
    .id_use_pc(id_use_pc), .id_alu_ctrl(id_alu_ctrl), .id_rd_addr(id_rd_addr),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .ex_alu_result(ex_alu_result),
    .fwd_mem_we(fwd_mem_we), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
    .fwd_wb_we(fwd_wb_we), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
    .ex_ready(ex_ready), .flush(flush), .d1(d1), .d2(d2), .control(control),
    .ex_valid(ex_valid), .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_store_data(ex_store_data), .load_use_stall(load_use_stall)
  );

  always #5 clk = ~clk;

  function automatic logic [107:0] pack(input logic v, input logic [3:0] c, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] s,
                                        input logic [4:0] rd, input logic rw, input logic mr);
    return {v, c, a, b, s, rd, rw, mr};
  endfunction

  task automatic idle();
    id_valid = 1'b0; id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; id_rd_addr = 5'd0;
    id_rs1_data = 32'd0; id_rs2_data = 32'd0; id_imm = 32'd0; id_pc = 32'd0;
    id_use_imm = 1'b0; id_use_pc = 1'b0; id_reg_write = 1'b0; id_mem_read = 1'b0;
    id_alu_ctrl = 4'd0; ex_alu_result = 32'd0; fwd_mem_we = 1'b0; fwd_mem_rd = 5'd0;
    fwd_mem_data = 32'd0; fwd_wb_we = 1'b0; fwd_wb_rd = 5'd0; fwd_wb_data = 32'd0;
    ex_ready = 1'b1; flush = 1'b0;
  endtask

  task automatic instr(input logic [4:0] rs1, input logic [31:0] r1d, input logic [4:0] rs2,
                       input logic [31:0] r2d, input logic [3:0] ctrl, input logic [4:0] rd,
                       input logic rw, input logic mr);
    id_valid = 1'b1; id_rs1_addr = rs1; id_rs1_data = r1d; id_rs2_addr = rs2; id_rs2_data = r2d;
    id_alu_ctrl = ctrl; id_rd_addr = rd; id_reg_write = rw; id_mem_read = mr;
    id_use_imm = 1'b0; id_use_pc = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    #2;
    n_checks++;
    if (obs !== BUBBLE) begin
      n_fail++; $display("FAIL reset_state: got %h expected %h", obs, BUBBLE);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_capture();
    instr(5'd1, 32'h10101010, 5'd2, 32'h01010101, 4'b0010, 5'd3, 1'b1, 1'b0);
    #1;
    n_checks++;
    if (id_ready !== 1'b1) begin
      n_fail++; $display("FAIL capture_ready: got %b expected 1", id_ready);
    end
    sb.push_back(pack(1'b1, 4'b0010, 32'h10101010, 32'h01010101, 32'h01010101, 5'd3, 1'b1, 1'b0));
    @(posedge clk); #1;
    exp_v = sb.pop_front(); n_checks++;
    if (obs !== exp_v) begin
      n_fail++; $display("FAIL capture_out: got %h expected %h", obs, exp_v);
    end
    idle();
  endtask

  task automatic test_forward();
    // EX occupant that writes x5
    instr(5'd1, 32'h1, 5'd2, 32'h2, 4'b0001, 5'd5, 1'b1, 1'b0);
    sb.push_back(pack(1'b1, 4'b0001, 32'h1, 32'h2, 32'h2, 5'd5, 1'b1, 1'b0));
    @(posedge clk); #1;
    exp_v = sb.pop_front(); n_checks++;
    if (obs !== exp_v) begin
      n_fail++; $display("FAIL fwd_setup: got %h expected %h", obs, exp_v);
    end
    instr(5'd5, 32'h55555555, 5'd6, 32'h00000066, 4'b0011, 5'd0, 1'b0, 1'b0);
    ex_alu_result = 32'hAAAA0000;
    fwd_mem_we = 1'b1; fwd_mem_rd = 5'd5; fwd_mem_data = 32'h11111111;
    fwd_wb_we = 1'b1; fwd_wb_rd = 5'd5; fwd_wb_data = 32'h22222222;
    sb.push_back(pack(1'b1, 4'b0011, 32'hAAAA0000, 32'h66, 32'h66, 5'd0, 1'b0, 1'b0));
    @(posedge clk); #1;
    exp_v = sb.pop_front(); n_checks++;
    if (obs !== exp_v) begin
      n_fail++; $display("FAIL fwd_ex: got %h expected %h", obs, exp_v);
    end
    // occupant no longer writes, so EX no longer matches
    sb.push_back(pack(1'b1, 4'b0011, 32'h11111111, 32'h66, 32'h66, 5'd0, 1'b0, 1'b0));
    @(posedge clk); #1;
    exp_v = sb.pop_front(); n_checks++;
    if (obs !== exp_v) begin
      n_fail++; $display("FAIL fwd_mem: got %h expected %h", obs, exp_v);
    end
    fwd_mem_we = 1'b0;
    id_rd_addr = 5'd0; id_reg_write = 1'b1;
    sb.push_back(pack(1'b1, 4'b0011, 32'h22222222, 32'h66, 32'h66, 5'd0, 1'b1, 1'b0));
    @(posedge clk); #1;
    exp_v = sb.pop_front(); n_checks++;
    if (obs !== exp_v) begin
      n_fail++; $display("FAIL fwd_wb: got %h expected %h", obs, exp_v);
    end
    // every source claims x0 (EX occupant writes x0 too); x0 reads as zero
    instr(5'd0, 32'h12345678, 5'd0, 32'h87654321, 4'b0100, 5'd0, 1'b1, 1'b0);
    id_use_imm = 1'b1; id_imm = 32'h00000ABC;
    fwd_mem_we = 1'b1; fwd_mem_rd = 5'd0; fwd_wb_we = 1'b1; fwd_wb_rd = 5'd0;
    sb.push_back(pack(1'b1, 4'b0100, 32'h0, 32'h00000ABC, 32'h0, 5'd0, 1'b1, 1'b0));
    @(posedge clk); #1;
    exp_v = sb.pop_front(); n_checks++;
    if (obs !== exp_v) begin
      n_fail++; $display("FAIL fwd_x0: got %h expected %h", obs, exp_v);
    end
    instr(5'd9, 32'h99, 5'd10, 32'hA0, 4'b0101, 5'd0, 1'b0, 1'b0);
    fwd_mem_we = 1'b0; fwd_wb_we = 1'b0;
    id_use_pc = 1'b1; id_pc = 32'h00400010;
    sb.push_back(pack(1'b1, 4'b0101, 32'h00400010, 32'hA0, 32'hA0, 5'd0, 1'b0, 1'b0));
    @(posedge clk); #1;
    exp_v = sb.pop_front(); n_checks++;
    if (obs !== exp_v) begin
      n_fail++; $display("FAIL use_pc: got %h expected %h", obs, exp_v);
    end
    idle();
  endtask

  task automatic test_load_use();
    instr(5'd1, 32'h1, 5'd2, 32'h2, 4'b0000, 5'd7, 1'b1, 1'b1);
    sb.push_back(pack(1'b1, 4'b0000, 32'h1, 32'h2, 32'h2, 5'd7, 1'b1, 1'b1));
    @(posedge clk); #1;
    exp_v = sb.pop_front(); n_checks++;
    if (obs !== exp_v) begin
      n_fail++; $display("FAIL load_issue: got %h expected %h", obs, exp_v);
    end
    instr(5'd8, 32'h80, 5'd7, 32'h77, 4'b0110, 5'd9, 1'b1, 1'b0);
    ex_alu_result = 32'h5555AAAA;
    #1;
    n_checks++;
    if ({load_use_stall, id_ready} !== 2'b10) begin
      n_fail++; $display("FAIL lu_stall: got stall=%b ready=%b expected stall=1 ready=0",
                         load_use_stall, id_ready);
    end
    sb.push_back(BUBBLE);
    @(posedge clk); #1;
    exp_v = sb.pop_front(); n_checks++;
    if (obs !== exp_v) begin
      n_fail++; $display("FAIL lu_bubble: got %h expected %h", obs, exp_v);
    end
    fwd_mem_we = 1'b1; fwd_mem_rd = 5'd7; fwd_mem_data = 32'hDEADBEEF;
    #1;
    n_checks++;
    if ({load_use_stall, id_ready} !== 2'b01) begin
      n_fail++; $display("FAIL lu_release: got stall=%b ready=%b expected stall=0 ready=1",
                         load_use_stall, id_ready);
    end
    sb.push_back(pack(1'b1, 4'b0110, 32'h80, 32'hDEADBEEF, 32'hDEADBEEF, 5'd9, 1'b1, 1'b0));
    @(posedge clk); #1;
    exp_v = sb.pop_front(); n_checks++;
    if (obs !== exp_v) begin
      n_fail++; $display("FAIL lu_forward: got %h expected %h", obs, exp_v);
    end
    idle();
  endtask

  task automatic test_back_pressure();
    logic [107:0] held;
    instr(5'd11, 32'hB1, 5'd12, 32'hC2, 4'b0111, 5'd13, 1'b1, 1'b0);
    held = pack(1'b1, 4'b0111, 32'hB1, 32'hC2, 32'hC2, 5'd13, 1'b1, 1'b0);
    sb.push_back(held);
    @(posedge clk); #1;
    exp_v = sb.pop_front(); n_checks++;
    if (obs !== exp_v) begin
      n_fail++; $display("FAIL bp_first: got %h expected %h", obs, exp_v);
    end
    instr(5'd14, 32'hE4, 5'd15, 32'hF5, 4'b1000, 5'd16, 1'b1, 1'b0);
    ex_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (id_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_ready cycle %0d: got %b expected 0", i, id_ready);
      end
      sb.push_back(held);
      @(posedge clk); #1;
      exp_v = sb.pop_front(); n_checks++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL bp_hold cycle %0d: got %h expected %h", i, obs, exp_v);
      end
    end
    ex_ready = 1'b1;
    sb.push_back(pack(1'b1, 4'b1000, 32'hE4, 32'hF5, 32'hF5, 5'd16, 1'b1, 1'b0));
    @(posedge clk); #1;
    exp_v = sb.pop_front(); n_checks++;
    if (obs !== exp_v) begin
      n_fail++; $display("FAIL bp_release: got %h expected %h", obs, exp_v);
    end
    idle();
    sb.push_back(BUBBLE);
    @(posedge clk); #1;
    exp_v = sb.pop_front(); n_checks++;
    if (obs !== exp_v) begin
      n_fail++; $display("FAIL bp_once: got %h expected %h", obs, exp_v);
    end
  endtask

  task automatic test_flush();
    instr(5'd1, 32'h1, 5'd2, 32'h2, 4'b0000, 5'd7, 1'b1, 1'b1);
    sb.push_back(pack(1'b1, 4'b0000, 32'h1, 32'h2, 32'h2, 5'd7, 1'b1, 1'b1));
    @(posedge clk); #1;
    exp_v = sb.pop_front(); n_checks++;
    if (obs !== exp_v) begin
      n_fail++; $display("FAIL flush_setup: got %h expected %h", obs, exp_v);
    end
    instr(5'd7, 32'h70, 5'd3, 32'h30, 4'b1001, 5'd4, 1'b1, 1'b0);
    ex_ready = 1'b0; flush = 1'b1;
    #1;
    n_checks++;
    if ({load_use_stall, id_ready} !== 2'b10) begin
      n_fail++; $display("FAIL flush_pre: got stall=%b ready=%b expected stall=1 ready=0",
                         load_use_stall, id_ready);
    end
    sb.push_back(BUBBLE);
    @(posedge clk); #1;
    exp_v = sb.pop_front(); n_checks++;
    if (obs !== exp_v) begin
      n_fail++; $display("FAIL flush_bubble: got %h expected %h", obs, exp_v);
    end
    idle();
  endtask

  task automatic test_reset_mid();
    instr(5'd17, 32'hCAFE0001, 5'd18, 32'hCAFE0002, 4'b1010, 5'd19, 1'b1, 1'b0);
    @(posedge clk); #1;
    idle();
    ex_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== BUBBLE) begin
      n_fail++; $display("FAIL reset_mid: got %h expected %h", obs, BUBBLE);
    end
    @(negedge clk); rst_n = 1'b1; ex_ready = 1'b1;
    instr(5'd20, 32'h20, 5'd21, 32'h21, 4'b1011, 5'd22, 1'b0, 1'b0);
    sb.push_back(pack(1'b1, 4'b1011, 32'h20, 32'h21, 32'h21, 5'd22, 1'b0, 1'b0));
    @(posedge clk); #1;
    exp_v = sb.pop_front(); n_checks++;
    if (obs !== exp_v) begin
      n_fail++; $display("FAIL reset_after: got %h expected %h", obs, exp_v);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_capture();
    test_forward();
    test_load_use();
    test_back_pressure();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register that feeds the ALU's d1, d2 and control inputs each cycle.
- Selects operands (register, immediate, PC) and resolves data hazards by forwarding from EX, MEM and WB.
- Detects load-use hazards, stalls decode, and inserts bubbles.
- Honours downstream back-pressure and pipeline flush.

Parameters:
XLEN, 32, datapath width
REG_AW, 5, register address width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
id_valid  input  1  decode holds an instruction
id_ready  output  1  stage accepts the decode instruction this cycle
id_rs1_addr  input  REG_AW  source 1 index
id_rs2_addr  input  REG_AW  source 2 index
id_rs1_data  input  XLEN  register-file read 1
id_rs2_data  input  XLEN  register-file read 2
id_imm  input  XLEN  decoded immediate
id_pc  input  XLEN  instruction PC
id_use_imm  input  1  d2 = immediate; rs2 not read for d2
id_use_pc  input  1  d1 = PC; rs1 not read
id_alu_ctrl  input  4  ALU control code
id_rd_addr  input  REG_AW  destination index
id_reg_write  input  1  instruction writes rd
id_mem_read  input  1  instruction is a load
ex_alu_result  input  XLEN  ALU result of the current EX occupant, fed back
fwd_mem_we  input  1  MEM stage writes a register
fwd_mem_rd  input  REG_AW  MEM destination
fwd_mem_data  input  XLEN  MEM result
fwd_wb_we  input  1  WB stage writes a register
fwd_wb_rd  input  REG_AW  WB destination
fwd_wb_data  input  XLEN  WB write data
ex_ready  input  1  downstream accepts the EX occupant
flush  input  1  kill EX occupant and decode instruction
d1  output  XLEN  registered ALU operand 1
d2  output  XLEN  registered ALU operand 2
control  output  4  registered ALU control
ex_valid  output  1  EX occupant is real
ex_rd_addr  output  REG_AW  registered destination
ex_reg_write  output  1  registered write enable
ex_mem_read  output  1  registered load flag
ex_store_data  output  XLEN  forwarded rs2 value, kept for stores
load_use_stall  output  1  hazard stall indicator

Behaviour:
- Bubble state: ex_valid=0; d1, d2, ex_store_data=0; control=4'b0000; ex_rd_addr=0; ex_reg_write=0; ex_mem_read=0.
- Reset: asserting rst_n low forces the bubble state immediately, independent of clk. Any occupant, including one held by a stall, is discarded. After deassertion the first edge behaves normally.
- Forwarding per source operand s (rs1, rs2), resolved combinationally at capture:
  - Address 0 always yields 0; it is never forwarded.
  - Priority 1, EX: ex_valid & ex_reg_write & !ex_mem_read & ex_rd_addr==s -> ex_alu_result.
  - Priority 2, MEM: fwd_mem_we & fwd_mem_rd==s -> fwd_mem_data.
  - Priority 3, WB: fwd_wb_we & fwd_wb_rd==s -> fwd_wb_data.
  - Otherwise: register-file data.
- Operand select:
  - d1 = id_use_pc ? id_pc : fwd(rs1).
  - d2 = id_use_imm ? id_imm : fwd(rs2).
  - ex_store_data = fwd(rs2) always.
- Load-use hazard: load_use_stall = id_valid & ex_valid & ex_mem_read & ex_rd_addr!=0 & ((!id_use_pc & rs1==ex_rd_addr) | rs2==ex_rd_addr).
  - The rs2 match applies even when id_use_imm=1, so stores stall conservatively.
- Handshake: id_ready = ex_ready & !load_use_stall & !flush.
- Per rising edge, in priority order:
  1. flush=1 -> bubble, regardless of ex_ready.
  2. ex_ready=0 -> hold all outputs unchanged.
  3. id_valid & id_ready -> capture the decode instruction; ex_valid=1.
  4. Otherwise, including a stall -> bubble.
- Latency: one cycle from decode acceptance to the outputs.
- No instruction is duplicated or dropped: while stalled, decode holds its inputs stable and re-presents them.
- Simultaneous flush and stall: flush wins; the stall has no effect.

Test Plan:
- Reset mid-operation: load a real instruction, then pull rst_n low between edges -> all outputs are bubble values immediately, ex_valid=0.
- Plain capture: rs1_data=0x10101010, rs2_data=0x01010101, ctrl=4'b0010, no hazards -> next cycle d1=0x10101010, d2=0x01010101, control=4'b0010, ex_valid=1.
- Forward priority: EX occupant writes x5 with ex_alu_result=0xAAAA0000; MEM writes x5 with 0x11111111; WB writes x5 with 0x22222222; new instruction reads rs1=x5 -> d1=0xAAAA0000.
  - Drop the EX match -> d1=0x11111111.
  - Also drop the MEM match -> d1=0x22222222.
  - rs1=x0 with all sources claiming x0 -> d1=0.
- Load-use: load to x7 in EX, next instruction reads rs2=x7 -> load_use_stall=1, id_ready=0.
  - Next cycle: ex_valid=0, control=0.
  - Following cycle, with the value forwarded from MEM (0xDEADBEEF) -> d2=0xDEADBEEF, ex_valid=1.
- Back-pressure: ex_ready=0 for 3 cycles with id_valid=1 -> outputs frozen, id_ready=0.
  - On release the held decode instruction is captured exactly once.
- Flush: flush=1 together with ex_ready=0 and a pending stall -> next edge is a bubble; the decode instruction is not captured.
